// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the execute-stage ALU.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_MUL = 4'b1000;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_e;

   function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps,
// keeping only the low WIDTH bits of the product.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [WIDTH-1:0] acc_next_s;

   // Partial sum for the current step.
   always_comb begin
      if (mplier_r[0]) begin
         acc_next_s = acc_r + mcand_r;
      end else begin
         acc_next_s = acc_r;
      end
   end

   // The product is taken from the final step's sum so the result is ready on the last edge.
   assign busy    = (cnt_r != {CW{1'b0}});
   assign done    = busy && (cnt_r == CW'(1));
   assign product = acc_next_s;

   // Counter, accumulator and shifted operands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r    <= {CW{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         mcand_r  <= {WIDTH{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
      end else if (flush) begin
         cnt_r    <= {CW{1'b0}};
      end else if (start) begin
         cnt_r    <= CW'(WIDTH);
         acc_r    <= {WIDTH{1'b0}};
         mcand_r  <= op_a;
         mplier_r <= op_b;
      end else if (busy) begin
         cnt_r    <= cnt_r - CW'(1);
         acc_r    <= acc_next_s;
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
      end
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, iterative MUL, and a
// valid/ready output register feeding the EX/MEM boundary.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [4:0]       rd_in,
   input  logic             reg_write_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [4:0]       rd_out,
   output logic             reg_write_out,
   output logic             busy
);

   alu_state_e       state_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] result_r;
   logic             zero_r;
   logic             overflow_r;
   logic [4:0]       rd_r;
   logic             reg_write_r;
   logic [4:0]       rd_hold_r;
   logic             rw_hold_r;

   logic             accept_s;
   logic             is_mul_s;
   logic             mul_start_s;
   logic             mul_busy_s;
   logic             mul_done_s;
   logic [WIDTH-1:0] mul_product_s;
   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] diff_s;
   logic [WIDTH-1:0] sc_result_s;
   logic             sc_ovf_s;
   logic             load_s;
   logic [WIDTH-1:0] ld_result_s;
   logic             ld_ovf_s;
   logic [4:0]       ld_rd_s;
   logic             ld_rw_s;

   assign in_ready    = (state_r == ST_IDLE) && (!out_valid_r || out_ready) && !reset;
   assign accept_s    = in_valid && in_ready;
   assign is_mul_s    = (alu_control == ALU_MUL);
   assign mul_start_s = accept_s && is_mul_s && !flush;
   assign sum_s       = src_a + src_b;
   assign diff_s      = src_a - src_b;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start_s),
      .flush   (flush),
      .op_a    (src_a),
      .op_b    (src_b),
      .busy    (mul_busy_s),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // Single-cycle datapath; undefined codes (and MUL, handled by the engine) give 0.
   always_comb begin
      sc_result_s = {WIDTH{1'b0}};
      sc_ovf_s    = 1'b0;
      case (alu_control)
         ALU_AND: sc_result_s = src_a & src_b;
         ALU_OR:  sc_result_s = src_a | src_b;
         ALU_NOR: sc_result_s = ~(src_a | src_b);
         ALU_ADD: begin
            sc_result_s = sum_s;
            sc_ovf_s    = add_overflow(src_a[WIDTH-1], src_b[WIDTH-1], sum_s[WIDTH-1]);
         end
         ALU_SUB: begin
            sc_result_s = diff_s;
            sc_ovf_s    = sub_overflow(src_a[WIDTH-1], src_b[WIDTH-1], diff_s[WIDTH-1]);
         end
         ALU_SLT: sc_result_s = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: begin
            sc_result_s = {WIDTH{1'b0}};
            sc_ovf_s    = 1'b0;
         end
      endcase
   end

   // Output-register source: a finishing MUL (in_ready is low then, so no conflict) or a new single-cycle op.
   always_comb begin
      if (mul_done_s) begin
         ld_result_s = mul_product_s;
         ld_ovf_s    = 1'b0;
         ld_rd_s     = rd_hold_r;
         ld_rw_s     = rw_hold_r;
         load_s      = 1'b1;
      end else begin
         ld_result_s = sc_result_s;
         ld_ovf_s    = sc_ovf_s;
         ld_rd_s     = rd_in;
         ld_rw_s     = reg_write_in;
         load_s      = accept_s && !is_mul_s;
      end
   end

   // Control state; also leaves MUL if the engine is no longer running.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         rd_hold_r <= 5'd0;
         rw_hold_r <= 1'b0;
      end else if (flush) begin
         state_r   <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (mul_start_s) begin
                  state_r   <= ST_MUL;
                  rd_hold_r <= rd_in;
                  rw_hold_r <= reg_write_in;
               end
            end
            ST_MUL: begin
               if (mul_done_s || !mul_busy_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Output register: load wins over a same-edge handshake, so there is no bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         zero_r      <= 1'b0;
         overflow_r  <= 1'b0;
         rd_r        <= 5'd0;
         reg_write_r <= 1'b0;
      end else if (flush) begin
         out_valid_r <= 1'b0;
      end else if (load_s) begin
         out_valid_r <= 1'b1;
         result_r    <= ld_result_s;
         zero_r      <= (ld_result_s == {WIDTH{1'b0}});
         overflow_r  <= ld_ovf_s;
         rd_r        <= ld_rd_s;
         reg_write_r <= ld_rw_s;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign out_valid     = out_valid_r;
   assign result        = result_r;
   assign zero          = zero_r;
   assign overflow      = overflow_r;
   assign rd_out        = rd_r;
   assign reg_write_out = reg_write_r;
   assign busy          = (state_r == ST_MUL);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed corner cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [3:0]  alu_control;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [4:0]  rd_in;
   logic        reg_write_in;
   logic        flush;
   logic        out_ready;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic [4:0]  rd_out;
   logic        reg_write_out;
   logic        busy;

   typedef struct {
      logic [31:0] r;
      logic        z;
      logic        ov;
      logic [4:0]  rd;
      logic        rw;
   } exp_t;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_exec_stage dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .alu_control   (alu_control),
      .src_a         (src_a),
      .src_b         (src_b),
      .rd_in         (rd_in),
      .reg_write_in  (reg_write_in),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .zero          (zero),
      .overflow      (overflow),
      .rd_out        (rd_out),
      .reg_write_out (reg_write_out),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain arithmetic on the operation definitions.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input logic rw);
      exp_t        e;
      longint      s;
      logic [63:0] p;
      e.r  = 32'd0;
      e.ov = 1'b0;
      e.rd = rd;
      e.rw = rw;
      case (op)
         4'b0000: e.r = a & b;
         4'b0001: e.r = a | b;
         4'b1100: e.r = ~(a | b);
         4'b0010: begin
            s    = longint'($signed(a)) + longint'($signed(b));
            e.r  = a + b;
            e.ov = (s != longint'($signed(e.r)));
         end
         4'b0110: begin
            s    = longint'($signed(a)) - longint'($signed(b));
            e.r  = a - b;
            e.ov = (s != longint'($signed(e.r)));
         end
         4'b0111: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1000: begin
            p   = {32'd0, a} * {32'd0, b};
            e.r = p[31:0];
         end
         default: e.r = 32'd0;
      endcase
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   task automatic expect_out(input string tag, input exp_t e);
      check(tag, {23'd0, out_valid, result, zero, overflow, rd_out, reg_write_out},
                 {23'd0, 1'b1, e.r, e.z, e.ov, e.rd, e.rw});
   endtask

   // Offers one op, waits (bounded) for in_ready, returns 1ns after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw);
      int budget = 100;
      alu_control  = op;
      src_a        = a;
      src_b        = b;
      rd_in        = rd;
      reg_write_in = rw;
      in_valid     = 1'b1;
      #1;
      while (!in_ready && budget > 0) begin
         step();
         budget--;
      end
      if (budget == 0) check("issue_wait", {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0]  ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                               4'b1100, 4'b0011, 4'b1111, 4'b1101, 4'b1000};
      logic [31:0] edgev [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
      int          cnt;
      exp_t        e;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      alu_control = 4'd0; src_a = 32'd0; src_b = 32'd0; rd_in = 5'd0; reg_write_in = 1'b0;
      #2;
      check("reset_outs", {54'd0, out_valid, result[0], |result, zero, overflow, |rd_out,
                           reg_write_out, busy, in_ready, 1'b0}, 64'd0);
      step(); step();
      reset = 1'b0;
      #1;
      check("ready_after_reset", {63'd0, in_ready}, 64'd1);

      out_ready = 1'b1;
      issue(4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd3, 1'b1);
      expect_out("add_ovf", model(4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd3, 1'b1));
      check("add_ovf_result", {32'd0, result}, 64'h80000000);

      issue(4'b0110, 32'd5, 32'd5, 5'd4, 1'b1);
      expect_out("sub_zero", model(4'b0110, 32'd5, 32'd5, 5'd4, 1'b1));
      check("sub_zero_flag", {63'd0, zero}, 64'd1);

      issue(4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd5, 1'b0);
      check("slt_signed", {32'd0, result}, 64'd1);

      issue(4'b1000, 32'h0000FFFF, 32'h00010001, 5'd9, 1'b1);
      check("mul_start", {61'd0, busy, in_ready, out_valid}, 64'b100);
      cnt = 0;
      for (int k = 1; k < 32; k++) begin
         step();
         if (busy && !in_ready && !out_valid) cnt++;
      end
      check("mul_busy_cycles", 64'(cnt), 64'd31);
      step();
      expect_out("mul_result", model(4'b1000, 32'h0000FFFF, 32'h00010001, 5'd9, 1'b1));
      check("mul_result_val", {32'd0, result}, 64'hFFFFFFFF);
      check("mul_busy_drop", {63'd0, busy}, 64'd0);

      issue(4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd7, 1'b1);
      out_ready = 1'b0;
      e = model(4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd7, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         expect_out("hold_stable", e);
         check("hold_no_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      #1;
      check("hold_release_ready", {63'd0, in_ready}, 64'd1);
      step();
      check("hold_consumed", {63'd0, out_valid}, 64'd0);

      // Back-to-back single-cycle ops with out_ready high.
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         alu_control = ops[k]; src_a = $urandom; src_b = $urandom; rd_in = 5'(k + 10); reg_write_in = k[0];
         e = model(alu_control, src_a, src_b, rd_in, reg_write_in);
         #1;
         check("b2b_ready", {63'd0, in_ready}, 64'd1);
         step();
         expect_out("b2b_out", e);
      end
      in_valid = 1'b0;
      step();

      issue(4'b1000, $urandom, $urandom, 5'd1, 1'b1);
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_state", {61'd0, busy, out_valid, in_ready}, 64'b001);
      cnt = 0;
      repeat (40) begin
         step();
         if (out_valid) cnt++;
      end
      check("flush_no_result", 64'(cnt), 64'd0);

      issue(4'b1000, 32'h12345678, 32'h9ABCDEF0, 5'd2, 1'b1);
      repeat (5) step();
      #2;
      reset = 1'b1;
      #1;
      check("reset_mid_mul", {54'd0, out_valid, |result, zero, overflow, |rd_out,
                              reg_write_out, busy, in_ready, 2'b0}, 64'd0);
      step(); step();
      reset = 1'b0;
      issue(4'b0010, 32'd2, 32'd3, 5'd6, 1'b1);
      expect_out("add_after_reset", model(4'b0010, 32'd2, 32'd3, 5'd6, 1'b1));
      step();

      // Randomized traffic: accepted ops queued in order, popped on each output handshake.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) alu_control = 4'b1000;
         else alu_control = ops[$urandom_range(0, 8)];
         src_a = ($urandom_range(0, 3) == 0) ? edgev[$urandom_range(0, 4)] : $urandom;
         src_b = ($urandom_range(0, 3) == 0) ? edgev[$urandom_range(0, 4)] : $urandom;
         rd_in = 5'($urandom);
         reg_write_in = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #2;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("rand_unexpected", {63'd0, out_valid}, 64'd0);
            else begin
               e = sb.pop_front();
               expect_out("rand_out", e);
            end
         end
         if (in_valid && in_ready) sb.push_back(model(alu_control, src_a, src_b, rd_in, reg_write_in));
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         #2;
         if (out_valid) begin
            if (sb.size() == 0) check("drain_unexpected", {63'd0, out_valid}, 64'd0);
            else begin
               e = sb.pop_front();
               expect_out("drain_out", e);
            end
         end
         step();
      end
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage ALU for the pipeline, directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code plus two operands from the ID/EX boundary and produces a registered result with zero and overflow flags for the EX/MEM boundary. Single-cycle operations complete in one cycle. MUL runs on an iterative shift-add engine over WIDTH cycles. Valid/ready handshakes are used on both sides, and a synchronous flush supports branch squash.

## Interface
- WIDTH, 32, operand/result width; also MUL iteration count
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  upstream offers an operation
- in_ready  out  1  stage can accept this cycle
- alu_control  in  4  operation code from ALU control decoder
- src_a  in  WIDTH  operand A
- src_b  in  WIDTH  operand B
- rd_in  in  5  destination register tag, passed through
- reg_write_in  in  1  write-enable tag, passed through
- flush  in  1  synchronous squash of in-flight and output work
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream consumes result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only)
- rd_out  out  5  registered rd tag
- reg_write_out  out  1  registered write-enable tag
- busy  out  1  high while state == MUL

## Operation
- Codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, result 1 or 0); 1100 NOR.
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - Any other code: result 0, single-cycle.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. overflow = signed overflow for ADD/SUB; 0 for all other ops.
- States:
  - IDLE: accept on in_valid && in_ready.
    - Single-cycle op: load output register. Stay in IDLE.
    - MUL: latch operands and tags, load the iteration counter with WIDTH, go to MUL.
  - MUL: one shift-add step per cycle. When the counter reaches 0, load the output register and return to IDLE.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !reset.
  - Consequence: the output register is always empty for the whole duration of a MUL.
- Output register:
  - Holds result, zero, overflow and tags unchanged while out_valid && !out_ready.
  - Clears out_valid on a handshake unless it is reloaded on the same edge.
- Flush (synchronous, highest priority after reset):
  - out_valid is cleared.
  - A MUL in progress is aborted to IDLE.
  - Any operation accepted on the same edge is discarded.
- Reset, asynchronous, including mid-MUL:
  - state = IDLE, counter = 0.
  - out_valid, result, zero, overflow, rd_out, reg_write_out and busy = 0.
  - in_ready = 0 while reset is asserted.

## Timing
- Single-cycle op accepted at edge N: out_valid = 1 after edge N, i.e. 1-cycle latency. Back-to-back throughput is 1 per cycle when out_ready is held high.
- MUL accepted at edge N:
  - busy is high from after edge N until after edge N+WIDTH.
  - out_valid = 1 after edge N+WIDTH, i.e. WIDTH-cycle latency.
  - in_ready is low throughout.
- zero and overflow are registered alongside result; they are never combinational from the inputs.
- Simultaneous out_ready handshake and new accept on the same edge: the new result replaces the old one with no bubble.

## Structure
- Shared package alu_pkg:
  - ALU control code constants, shared with the ALU control decoder.
  - State encoding (IDLE, MUL).
  - The WIDTH default.
- Sub-module alu_mul_iter contains the shift-add multiplier:
  - Inputs: start, operands, flush.
  - Outputs: busy, done, product.
  - Holds the counter, accumulator and shifted operands.
- The top level holds the handshake logic, the single-cycle datapath and the output register.

## Test plan
- ADD, src_a=0x7FFFFFFF, src_b=0x00000001 -> one cycle later: result=0x80000000, overflow=1, zero=0.
- SUB 5-5 -> result=0, zero=1, overflow=0. SLT src_a=0xFFFFFFFF, src_b=0x00000001 -> result=1.
- MUL 0x0000FFFF × 0x00010001 accepted at edge N:
  - result=0xFFFFFFFF with out_valid rising after edge N+32.
  - busy high for 32 cycles; in_ready low throughout.
- Hold out_ready=0 for 3 cycles with a valid OR result (0xF0F0F0F0 | 0x0F0F0F0F):
  - result stays 0xFFFFFFFF and tags are stable.
  - in_ready stays low until the handshake.
- flush asserted 10 cycles into a MUL: no out_valid; busy drops after that edge; in_ready=1 on the next cycle.
- reset asserted mid-MUL:
  - All outputs are 0 immediately, with no clock edge required.
  - After release, an ADD 2+3 produces 5 with 1-cycle latency.
